// File: rtl/sample_accum.sv
// Block-sum decimator: reads 2^SAMPLE_RATE unsigned samples from a standard-read
// input FIFO, sums them, and writes one widened sum per block to the output FIFO.
module sample_accum #(
    parameter int SAMPLE_RATE = 4,
    parameter int DATA_WIDTH  = 14
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    input  logic                              infifo_empty,
    output logic                              infifo_rd_en,
    input  logic [DATA_WIDTH-1:0]             infifo_dout,
    input  logic                              outfifo_full,
    output logic                              outfifo_wr_en,
    output logic [DATA_WIDTH+SAMPLE_RATE-1:0] outfifo_din,
    output logic                              busy
);

    localparam int             CW   = SAMPLE_RATE + 1;
    localparam int             SW   = DATA_WIDTH + SAMPLE_RATE;
    localparam logic [CW-1:0]  N    = CW'(2 ** SAMPLE_RATE);
    localparam logic [CW-1:0]  N_M1 = CW'(2 ** SAMPLE_RATE - 1);

    typedef enum logic {
        ACC,
        WRITE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] rd_cnt, add_cnt;
    logic          rd_vld;
    logic [SW-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        infifo_rd_en  = 1'b0;
        outfifo_wr_en = 1'b0;
        case (state)
            ACC: begin
                infifo_rd_en = !infifo_empty && (rd_cnt < N);
                if (rd_vld && (add_cnt == N_M1)) state_nxt = WRITE;
            end
            WRITE: begin
                outfifo_wr_en = !outfifo_full;
                if (!outfifo_full) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
        if (clr) begin
            infifo_rd_en  = 1'b0;
            outfifo_wr_en = 1'b0;
            state_nxt     = ACC;
        end
        // Keep the read strobe quiet while reset is held, even with data waiting.
        if (!rst_n) infifo_rd_en = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            rd_cnt  <= '0;
            add_cnt <= '0;
            rd_vld  <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            rd_cnt  <= '0;
            add_cnt <= '0;
            rd_vld  <= 1'b0;
        end else if (outfifo_wr_en) begin
            acc     <= '0;
            rd_cnt  <= '0;
            add_cnt <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= infifo_rd_en;
            if (infifo_rd_en) rd_cnt <= rd_cnt + 1'b1;
            // Data arrives one cycle after its strobe; rd_vld marks that cycle.
            if (rd_vld) begin
                acc     <= acc + SW'(infifo_dout);
                add_cnt <= add_cnt + 1'b1;
            end
        end
    end

    assign outfifo_din = acc;
    assign busy        = (state == WRITE) || (rd_cnt != '0);

endmodule

// File: tb/tb_sample_accum.sv
// Randomized directed bench for sample_accum (default parameters, 16-sample blocks):
// an input-FIFO model feeds a sample stream and expected sums come from plain addition.
module tb_sample_accum;

    localparam int SR = 4;
    localparam int DW = 14;
    localparam int NB = 2 ** SR;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          infifo_empty;
    logic          infifo_rd_en;
    logic [DW-1:0] infifo_dout;
    logic          outfifo_full;
    logic          outfifo_wr_en;
    logic [DW+SR-1:0] outfifo_din;
    logic          busy;

    sample_accum #(.SAMPLE_RATE(SR), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .infifo_empty (infifo_empty),
        .infifo_rd_en (infifo_rd_en),
        .infifo_dout  (infifo_dout),
        .outfifo_full (outfifo_full),
        .outfifo_wr_en(outfifo_wr_en),
        .outfifo_din  (outfifo_din),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]    samples[$];
    logic [DW+SR-1:0] out_q[$];
    int               rd_cyc[$];
    int               wr_cyc[$];
    int               n_avail  = 0;
    int               rd_ptr   = 0;
    int               cyc      = 0;
    int               spurious = 0;
    logic             starve;
    int               total    = 0;
    int               passed   = 0;

    assign infifo_empty = starve || (rd_ptr >= n_avail);

    // Input FIFO (standard read) and output FIFO capture.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (infifo_rd_en && infifo_empty) spurious++;
        if (infifo_rd_en) begin
            if (rd_ptr < n_avail) infifo_dout <= samples[rd_ptr];
            rd_ptr <= rd_ptr + 1;
            rd_cyc.push_back(cyc);
        end
        if (outfifo_wr_en) begin
            out_q.push_back(outfifo_din);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        samples.push_back(v);
        n_avail++;
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) push(DW'($urandom_range(0, 2 ** DW - 1)));
    endtask

    function automatic longint block_sum(input int start);
        longint s = 0;
        for (int i = start; i < start + NB; i++) s += longint'(samples[i]);
        return s;
    endfunction

    task automatic wait_reads(input int target);
        int n = 0;
        while (rd_ptr < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("read_wait", longint'(rd_ptr >= target), 1);
    endtask

    task automatic wait_outputs(input int target);
        int n = 0;
        while (out_q.size() < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("write_wait", longint'(out_q.size()), longint'(target));
    endtask

    initial begin
        int  base;
        int  busy_drop;
        int  k;

        rst_n        = 1'b1;
        clr          = 1'b0;
        outfifo_full = 1'b0;
        starve       = 1'b0;
        #1 rst_n     = 1'b0;

        // Reset state, with data already waiting in the input FIFO.
        push_random(2 * NB);
        repeat (2) @(negedge clk);
        check("rst_rd_en", longint'(infifo_rd_en), 0);
        check("rst_wr_en", longint'(outfifo_wr_en), 0);
        check("rst_din", longint'(outfifo_din), 0);
        check("rst_busy", longint'(busy), 0);
        rst_n = 1'b1;

        // Two back-to-back random blocks: sums, latency and throughput.
        wait_outputs(2);
        check("blk0_sum", longint'(out_q[0]), block_sum(0));
        check("blk1_sum", longint'(out_q[1]), block_sum(NB));
        check("wr_after_last_rd", longint'(wr_cyc[0] - rd_cyc[NB-1]), 2);
        check("next_rd_after_wr", longint'(rd_cyc[NB] - wr_cyc[0]), 1);
        check("block_period", longint'(wr_cyc[1] - wr_cyc[0]), NB + 2);

        // Full-scale block, then a random block that must start from zero.
        for (int i = 0; i < NB; i++) push(DW'(2 ** DW - 1));
        wait_outputs(3);
        check("fullscale_sum", longint'(out_q[2]), 262128);
        push_random(NB);
        wait_outputs(4);
        check("after_fullscale_sum", longint'(out_q[3]), block_sum(3 * NB));

        // Output backpressure: full held for 5 cycles on entering WRITE.
        base = n_avail;
        outfifo_full = 1'b1;
        push_random(NB);
        wait_reads(base + NB);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_wr_en", longint'(outfifo_wr_en), 0);
            check("stall_rd_en", longint'(infifo_rd_en), 0);
            check("stall_din", longint'(outfifo_din), block_sum(base));
            check("stall_busy", longint'(busy), 1);
            @(negedge clk);
        end
        check("stall_no_write", longint'(out_q.size()), 4);
        outfifo_full = 1'b0;
        #1;
        check("release_wr_en", longint'(outfifo_wr_en), 1);
        wait_outputs(5);
        check("stall_sum", longint'(out_q[4]), block_sum(base));

        // Input starvation: ramp 0..15 with empty toggling every 2 cycles.
        base = n_avail;
        starve = 1'b1;
        for (int i = 0; i < NB; i++) push(DW'(i));
        busy_drop = 0;
        k = 0;
        while (out_q.size() < 6 && k < 300) begin
            @(negedge clk);
            if (out_q.size() < 6 && rd_ptr > base && !busy) busy_drop++;
            if (k % 2 == 1) starve = ~starve;
            k++;
        end
        starve = 1'b0;
        check("starve_done", longint'(out_q.size()), 6);
        check("starve_sum", longint'(out_q[5]), 120);
        check("starve_busy_drop", longint'(busy_drop), 0);
        check("starve_reads", longint'(rd_ptr - base), NB);

        // Abort half-way: the partial block (and its in-flight word) is dropped.
        base = n_avail;
        push_random(NB / 2);
        wait_reads(base + NB / 2);
        for (int i = 0; i < NB; i++) push(DW'(5));
        clr = 1'b1;
        #1;
        check("clr_rd_en", longint'(infifo_rd_en), 0);
        @(negedge clk);
        clr = 1'b0;
        wait_outputs(7);
        check("after_clr_sum", longint'(out_q[6]), block_sum(base + NB / 2));
        check("after_clr_const", longint'(out_q[6]), 80);

        // Asynchronous reset between clock edges in the middle of a block.
        base = n_avail;
        push_random(NB);
        wait_reads(base + 5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd_en", longint'(infifo_rd_en), 0);
        check("arst_wr_en", longint'(outfifo_wr_en), 0);
        check("arst_din", longint'(outfifo_din), 0);
        check("arst_busy", longint'(busy), 0);
        repeat (2) @(negedge clk);
        base = rd_ptr;
        rst_n = 1'b1;
        push_random(NB);
        wait_outputs(8);
        check("after_arst_sum", longint'(out_q[7]), block_sum(base));

        repeat (5) @(negedge clk);
        check("spurious_reads", longint'(spurious), 0);
        check("total_writes", longint'(out_q.size()), 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sample_accum.md
# sample_accum

Block-sum decimator on the ADC capture path. Reads unsigned DATA_WIDTH-bit samples from the input FIFO, sums each group of 2^SAMPLE_RATE consecutive samples, and writes one (DATA_WIDTH+SAMPLE_RATE)-bit sum per group into the output FIFO. It is the producer for the downstream scaling stage, which consumes the wide sum and the `busy` flag.

## Interface

- `SAMPLE_RATE`, default 4: samples per block = N = 2^SAMPLE_RATE.
- `DATA_WIDTH`, default 14: input sample width, unsigned.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous block abort/flush.
- `infifo_empty` in 1: input FIFO empty flag.
- `infifo_rd_en` out 1: input FIFO read strobe.
- `infifo_dout` in DATA_WIDTH: input FIFO data, valid the cycle after `infifo_rd_en` (standard read, not FWFT).
- `outfifo_full` in 1: output FIFO full flag.
- `outfifo_wr_en` out 1: output FIFO write strobe.
- `outfifo_din` out DATA_WIDTH+SAMPLE_RATE: block sum.
- `busy` out 1: block in progress or pending write.

## Operation

- Two states: ACC (reading and summing) and WRITE (holding a finished sum).
- Internal registers:
  - `rd_cnt` (0..N): reads issued in the current block.
  - `add_cnt` (0..N): samples added.
  - `rd_vld`: `infifo_rd_en` delayed one cycle.
  - `acc`: DATA_WIDTH+SAMPLE_RATE bits, drives `outfifo_din` directly.
- `infifo_rd_en = (state==ACC) && !infifo_empty && (rd_cnt<N) && !clr`. Combinational. Each asserted cycle increments `rd_cnt`.
- When `rd_vld` is 1 (and no `clr`): `acc <= acc + zero-extended infifo_dout` and `add_cnt++`.
- When the add that brings `add_cnt` to N completes, the next state is WRITE.
- In WRITE, `outfifo_wr_en = !outfifo_full`. Combinational.
  - On a write cycle, `acc`, `rd_cnt` and `add_cnt` clear to 0 and the state returns to ACC.
  - While `outfifo_full` is high, the block stays in WRITE, `acc` holds, and no reads are issued.
- Arithmetic: the maximum sum N·(2^DATA_WIDTH−1) fits in DATA_WIDTH+SAMPLE_RATE bits. No saturation logic; overflow is impossible by construction.
- `busy = (state==WRITE) || (rd_cnt!=0)`. Registered-signal combinational decode.
- `clr` (synchronous, highest priority after reset):
  - Forces `infifo_rd_en` and `outfifo_wr_en` to 0 that cycle.
  - Clears `acc`, both counters and `rd_vld`; state goes to ACC.
  - An in-flight read word is discarded. `clr` in WRITE means the sum is never written.
- Reset (`rst_n`=0, asynchronous):
  - State ACC; `acc`, `rd_cnt`, `add_cnt`, `rd_vld` = 0.
  - Therefore `infifo_rd_en`, `outfifo_wr_en`, `outfifo_din` and `busy` are all 0 while reset is held.
  - Reset mid-block drops the partial sum.
- `infifo_empty` going high mid-block pauses reads only. In-flight data still gets added; the sum stays exact.

## Timing

- Read latency: `rd_en` at cycle t → data added at the end of t+1.
- Last (Nth) `rd_en` at cycle t → state WRITE at t+2 → `outfifo_wr_en` at t+2 if not full.
- Back-to-back throughput: N+2 cycles per block with the input never empty and the output never full. The next block's first read is at t+3.
- `outfifo_din` is stable throughout WRITE, including every stall cycle.
- `outfifo_wr_en` is high for exactly one cycle per block.

## Test plan

- Sum of four samples, SAMPLE_RATE=2: feed 100, 200, 300, 400 with the FIFO never empty. Expect a single `outfifo_wr_en` pulse with `outfifo_din`=1000, exactly 2 cycles after the 4th `rd_en`.
- Full-scale, defaults: feed 16 samples of 16383. Expect `outfifo_din`=262128 (0x3FFF0) and a second block starting from 0.
- Output backpressure: hold `outfifo_full`=1 for 5 cycles on entering WRITE. Expect `wr_en` and `rd_en` low for those 5 cycles, `outfifo_din` stable, and the write in the cycle after `full` drops.
- Input starvation: toggle `infifo_empty` every 2 cycles during a 16-sample block of ramp values 0..15. Expect a sum of 120, `busy` high throughout, and no spurious reads.
- Abort: assert `clr` for one cycle after 2 of 4 samples (SAMPLE_RATE=2). Expect no write. The next 4 samples of value 5 write 20.
- Async reset: pull `rst_n` low mid-block between clock edges. Expect all outputs 0 immediately. After release, the first complete block sums correctly from 0.
